// File: rtl/bldc_commutation_sequencer.sv
// Six-step BLDC commutation: hall filter, sector decode, dead time,
// drive pattern generation and latched invalid-hall / stall faults.
module bldc_commutation_sequencer #(
  parameter int FILTER_CYCLES = 4,
  parameter int DEAD_CYCLES   = 54,
  parameter int STALL_CYCLES  = 54_000_000,
  parameter int COUNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   dir_ccw,
  input  logic                   pwm_in,
  input  logic                   fault_clear,
  input  logic [2:0]             hall_values,
  output logic [5:0]             phase_enable,
  output logic [2:0]             sector,
  output logic [1:0]             state,
  output logic                   fault,
  output logic [1:0]             fault_code,
  output logic [COUNT_WIDTH-1:0] commutation_count
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int DW = $clog2(DEAD_CYCLES + 1);
  localparam int SW = $clog2(STALL_CYCLES + 1);

  localparam logic [FW-1:0] FILT_MAX  = FW'(FILTER_CYCLES);
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES - 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DEAD  = 2'd1,
    S_DRIVE = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  function automatic logic [2:0] sector_of(input logic [2:0] h);
    logic [2:0] s;
    s = 3'd7;
    unique case (h)
      3'b101:  s = 3'd0;
      3'b100:  s = 3'd1;
      3'b110:  s = 3'd2;
      3'b010:  s = 3'd3;
      3'b011:  s = 3'd4;
      3'b001:  s = 3'd5;
      default: s = 3'd7;
    endcase
    return s;
  endfunction

  // {hi, lo} one-hot phase selects, A = 100, B = 010, C = 001
  function automatic logic [5:0] pattern_of(input logic [2:0] s,
                                            input logic       ccw);
    logic [2:0] hi;
    logic [2:0] lo;
    hi = 3'b000;
    lo = 3'b000;
    unique case (s)
      3'd0: begin hi = 3'b100; lo = 3'b010; end
      3'd1: begin hi = 3'b100; lo = 3'b001; end
      3'd2: begin hi = 3'b010; lo = 3'b001; end
      3'd3: begin hi = 3'b010; lo = 3'b100; end
      3'd4: begin hi = 3'b001; lo = 3'b100; end
      3'd5: begin hi = 3'b001; lo = 3'b010; end
      default: begin hi = 3'b000; lo = 3'b000; end
    endcase
    return ccw ? {lo, hi} : {hi, lo};
  endfunction

  logic [2:0]             hall_prev_q, hall_prev_d;
  logic [FW-1:0]          stable_q, stable_d;
  logic [2:0]             hall_filt_q, hall_filt_d;
  logic                   hall_ok_q, hall_ok_d;

  state_e                 state_q, state_d;
  logic [DW-1:0]          dead_q, dead_d;
  logic [SW-1:0]          stall_q, stall_d;
  logic [SW-1:0]          stall_inc;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [2:0]             drv_sec_q, drv_sec_d;
  logic                   drv_dir_q, drv_dir_d;
  logic                   fault_q, fault_d;
  logic [1:0]             code_q, code_d;
  logic [5:0]             phase_q, phase_d;
  logic [5:0]             pat;

  logic [2:0]             sector_w;
  logic                   invalid;

  always_comb begin
    hall_prev_d = hall_values;
    hall_filt_d = hall_filt_q;
    hall_ok_d   = hall_ok_q;
    stable_d    = stable_q;
    if (hall_values != hall_prev_q) begin
      stable_d = FW'(1);
    end else if (stable_q != FILT_MAX) begin
      stable_d = stable_q + FW'(1);
    end
    if (stable_d == FILT_MAX) begin
      hall_filt_d = hall_values;
      hall_ok_d   = 1'b1;
    end
  end

  assign sector_w  = hall_ok_q ? sector_of(hall_filt_q) : 3'd7;
  assign invalid   = hall_ok_q && (sector_w == 3'd7);
  assign stall_inc = stall_q + SW'(1);

  always_comb begin
    state_d   = state_q;
    dead_d    = dead_q;
    stall_d   = stall_q;
    count_d   = count_q;
    drv_sec_d = drv_sec_q;
    drv_dir_d = drv_dir_q;
    fault_d   = fault_q;
    code_d    = code_q;
    unique case (state_q)
      S_IDLE: begin
        stall_d = '0;
        if (invalid) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          code_d  = 2'd1;
        end else if (enable && hall_ok_q && sector_w != 3'd7) begin
          state_d = S_DEAD;
          dead_d  = DEAD_LOAD;
        end
      end
      S_DEAD: begin
        if (invalid) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          code_d  = 2'd1;
        end else if (!enable) begin
          state_d = S_IDLE;
        end else if (dead_q == '0) begin
          state_d   = S_DRIVE;
          drv_sec_d = sector_w;
          drv_dir_d = dir_ccw;
        end else begin
          dead_d = dead_q - DW'(1);
        end
      end
      S_DRIVE: begin
        stall_d = stall_inc;
        if (invalid) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          code_d  = 2'd1;
        end else if (stall_inc == STALL_MAX) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          code_d  = 2'd2;
        end else if (!enable) begin
          state_d = S_IDLE;
        end else if (sector_w != drv_sec_q) begin
          state_d = S_DEAD;
          dead_d  = DEAD_LOAD;
          stall_d = '0;
          count_d = count_q + COUNT_WIDTH'(1);
        end else if (dir_ccw != drv_dir_q) begin
          state_d = S_DEAD;
          dead_d  = DEAD_LOAD;
        end
      end
      S_FAULT: begin
        if (fault_clear && !enable) begin
          state_d = S_IDLE;
          fault_d = 1'b0;
          code_d  = 2'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // pattern is taken from the next-state view so any exit from DRIVE blanks at once
  always_comb begin
    pat     = pattern_of(drv_sec_d, drv_dir_d);
    phase_d = 6'b000000;
    if (state_d == S_DRIVE) begin
      phase_d = {pat[5:3] & {3{pwm_in}}, pat[2:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hall_prev_q <= 3'b000;
      stable_q    <= '0;
      hall_filt_q <= 3'b000;
      hall_ok_q   <= 1'b0;
      state_q     <= S_IDLE;
      dead_q      <= '0;
      stall_q     <= '0;
      count_q     <= '0;
      drv_sec_q   <= 3'd0;
      drv_dir_q   <= 1'b0;
      fault_q     <= 1'b0;
      code_q      <= 2'd0;
      phase_q     <= 6'b000000;
    end else begin
      hall_prev_q <= hall_prev_d;
      stable_q    <= stable_d;
      hall_filt_q <= hall_filt_d;
      hall_ok_q   <= hall_ok_d;
      state_q     <= state_d;
      dead_q      <= dead_d;
      stall_q     <= stall_d;
      count_q     <= count_d;
      drv_sec_q   <= drv_sec_d;
      drv_dir_q   <= drv_dir_d;
      fault_q     <= fault_d;
      code_q      <= code_d;
      phase_q     <= phase_d;
    end
  end

  assign phase_enable      = phase_q;
  assign sector            = sector_w;
  assign state             = state_q;
  assign fault             = fault_q;
  assign fault_code        = code_q;
  assign commutation_count = count_q;

endmodule
